// File: rtl/eye_scan_pkg.sv
// rtl/eye_scan_pkg.sv - shared FSM encodings, result record and width helpers for the eye region scanner
package eye_scan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE         = 3'd0;
    localparam state_t S_LOAD_EYE     = 3'd1;
    localparam state_t S_SCAN_MINMAX  = 3'd2;
    localparam state_t S_DRAIN_MINMAX = 3'd3;
    localparam state_t S_SCAN_COUNT   = 3'd4;
    localparam state_t S_DRAIN_COUNT  = 3'd5;
    localparam state_t S_EYE_DONE     = 3'd6;
    localparam state_t S_DONE         = 3'd7;

    // Default-width result record for downstream consumers of the per-eye result
    typedef struct packed {
        logic        error;
        logic [15:0] pupil;
        logic [15:0] sclera;
        logic [16:0] openness;
    } eye_result_t;

    function automatic int calc_log_h(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    function automatic int calc_log_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int calc_fb_size(input int height, input int width);
        return (height * width > 1) ? $clog2(height * width) : 1;
    endfunction

endpackage

// File: rtl/sliding_window_minmax.sv
// rtl/sliding_window_minmax.sv - min/max over the current sample and the previous WINDOW-1 samples
// clear marks the first sample of a new column; full means WINDOW samples of that column are present.
module sliding_window_minmax #(
    parameter int WINDOW     = 7,
    parameter int PIXEL_SIZE = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [PIXEL_SIZE-1:0] data,
    output logic [PIXEL_SIZE-1:0] win_min,
    output logic [PIXEL_SIZE-1:0] win_max,
    output logic                  full
);

    logic [PIXEL_SIZE-1:0] hist [WINDOW-1];
    logic [3:0]            fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= 4'd0;
            for (int i = 0; i < WINDOW - 1; i++) hist[i] <= '0;
        end else if (valid) begin
            hist[0] <= data;
            for (int i = 1; i < WINDOW - 1; i++) hist[i] <= hist[i-1];
            if (clear)
                fill <= 4'd1;
            else if (fill < 4'(WINDOW - 1))
                fill <= fill + 4'd1;
        end
    end

    // The incoming sample is part of the window so a count can be taken in the same cycle
    always_comb begin
        win_min = data;
        win_max = data;
        for (int i = 0; i < WINDOW - 1; i++) begin
            if (hist[i] < win_min) win_min = hist[i];
            if (hist[i] > win_max) win_max = hist[i];
        end
        full = valid && !clear && (fill >= 4'(WINDOW - 1));
    end

endmodule

// File: rtl/eye_region_scanner.sv
// rtl/eye_region_scanner.sv - two-pass per-eye pupil/sclera counter over frame buffer regions
// Optional EYE_REGION_STATS_EN adds result_min_out/result_max_out (pass-1 min/max).
module eye_region_scanner
    import eye_scan_pkg::*;
#(
    parameter int HEIGHT         = 320,
    parameter int WIDTH          = 180,
    parameter int PIXEL_SIZE     = 8,
    parameter int NUM_EYES       = 2,
    parameter int WINDOW         = 7,
    parameter int READ_LATENCY   = 2,
    parameter int LOW_THRESHOLD  = 90,
    parameter int HIGH_THRESHOLD = 160,
    parameter int DIFF_THRESHOLD = 16,
    parameter int COUNT_W        = 16,
    localparam int LOG_H   = calc_log_h(HEIGHT),
    localparam int LOG_W   = calc_log_w(WIDTH),
    localparam int FB_SIZE = calc_fb_size(HEIGHT, WIDTH),
    localparam int EYE_W   = (NUM_EYES > 1) ? $clog2(NUM_EYES) : 1
)(
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      start_in,
    input  logic [NUM_EYES*LOG_H-1:0] row_start_in,
    input  logic [NUM_EYES*LOG_H-1:0] row_end_in,
    input  logic [NUM_EYES*LOG_W-1:0] col_start_in,
    input  logic [NUM_EYES*LOG_W-1:0] col_end_in,
    output logic [FB_SIZE-1:0]        pixel_addr_out,
    output logic                      pixel_addr_valid_out,
    input  logic [PIXEL_SIZE-1:0]     pixel_in,
    output logic                      busy_out,
    output logic                      result_valid_out,
    output logic [EYE_W-1:0]          result_eye_out,
    output logic [COUNT_W-1:0]        result_pupil_out,
    output logic [COUNT_W-1:0]        result_sclera_out,
    output logic [COUNT_W:0]          result_openness_out,
    output logic                      result_error_out,
    output logic                      done_out
`ifdef EYE_REGION_STATS_EN
    ,
    output logic [PIXEL_SIZE-1:0]     result_min_out,
    output logic [PIXEL_SIZE-1:0]     result_max_out
`endif
);

    localparam int CW = PIXEL_SIZE + 1;

    state_t                    state;
    logic [EYE_W-1:0]          eye_idx;
    logic [NUM_EYES*LOG_H-1:0] row_start_q, row_end_q;
    logic [NUM_EYES*LOG_W-1:0] col_start_q, col_end_q;
    logic [LOG_H-1:0]          cur_row;
    logic [LOG_W-1:0]          cur_col;
    logic [FB_SIZE-1:0]        addr_q;
    logic                      addr_valid_q, addr_first_q;
    logic [READ_LATENCY-1:0]   vld_sr, first_sr;
    logic [2:0]                drain_cnt;
    logic [PIXEL_SIZE-1:0]     min_q, max_q;
    logic [COUNT_W-1:0]        pupil, sclera;
    logic                      err_q, busy_q, done_q, res_valid_q, res_err_q;
    logic [EYE_W-1:0]          res_eye_q;
    logic [COUNT_W-1:0]        res_pupil_q, res_sclera_q;
    logic [COUNT_W:0]          res_open_q;
    logic [PIXEL_SIZE-1:0]     win_min, win_max;
    logic                      win_full;

    wire [LOG_H-1:0] rs = row_start_q[eye_idx*LOG_H +: LOG_H];
    wire [LOG_H-1:0] re = row_end_q[eye_idx*LOG_H +: LOG_H];
    wire [LOG_W-1:0] cs = col_start_q[eye_idx*LOG_W +: LOG_W];
    wire [LOG_W-1:0] ce = col_end_q[eye_idx*LOG_W +: LOG_W];

    // Regions reaching outside the frame are rejected too, so no address past the buffer is issued
    wire region_err = (re < rs) || (ce < cs) ||
                      (re > LOG_H'(HEIGHT - 1)) || (ce > LOG_W'(WIDTH - 1));
    wire last_pix   = (cur_row == re) && (cur_col == ce);
    wire count_pass = (state == S_SCAN_COUNT) || (state == S_DRAIN_COUNT);
    wire pix_vld    = vld_sr[READ_LATENCY-1];
    wire pix_first  = first_sr[READ_LATENCY-1];

    wire pupil_hit  = {1'b0, win_max} <= ({1'b0, min_q} + CW'(DIFF_THRESHOLD));
    wire sclera_hit = ({1'b0, win_min} + CW'(DIFF_THRESHOLD)) >= {1'b0, max_q};

    sliding_window_minmax #(.WINDOW(WINDOW), .PIXEL_SIZE(PIXEL_SIZE)) u_window (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .clear   (pix_first),
        .valid   (pix_vld && count_pass),
        .data    (pixel_in),
        .win_min (win_min),
        .win_max (win_max),
        .full    (win_full)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_IDLE;
            eye_idx <= '0;
            row_start_q <= '0; row_end_q <= '0; col_start_q <= '0; col_end_q <= '0;
            cur_row <= '0; cur_col <= '0;
            addr_q <= '0; addr_valid_q <= 1'b0; addr_first_q <= 1'b0;
            vld_sr <= '0; first_sr <= '0; drain_cnt <= '0;
            min_q <= '0; max_q <= '0; pupil <= '0; sclera <= '0; err_q <= 1'b0;
            busy_q <= 1'b0; done_q <= 1'b0; res_valid_q <= 1'b0; res_err_q <= 1'b0;
            res_eye_q <= '0; res_pupil_q <= '0; res_sclera_q <= '0; res_open_q <= '0;
        end else begin
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            addr_valid_q <= 1'b0;
            vld_sr[0]    <= addr_valid_q;
            first_sr[0]  <= addr_first_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
            end

            case (state)
                S_IDLE: begin
                    // done_q blocks the cycle of the done pulse so a held start restarts one cycle later
                    if (start_in && !done_q) begin
                        row_start_q <= row_start_in; row_end_q <= row_end_in;
                        col_start_q <= col_start_in; col_end_q <= col_end_in;
                        eye_idx <= '0;
                        busy_q  <= 1'b1;
                        state   <= S_LOAD_EYE;
                    end
                end
                S_LOAD_EYE: begin
                    min_q   <= PIXEL_SIZE'(LOW_THRESHOLD);
                    max_q   <= PIXEL_SIZE'(HIGH_THRESHOLD);
                    pupil   <= '0;
                    sclera  <= '0;
                    err_q   <= region_err;
                    cur_row <= rs;
                    cur_col <= cs;
                    state   <= region_err ? S_EYE_DONE : S_SCAN_MINMAX;
                end
                S_SCAN_MINMAX, S_SCAN_COUNT: begin
                    addr_q       <= FB_SIZE'(cur_row) * FB_SIZE'(WIDTH) + FB_SIZE'(cur_col);
                    addr_valid_q <= 1'b1;
                    addr_first_q <= (cur_row == rs);
                    if (cur_row == re) begin
                        cur_row <= rs;
                        cur_col <= cur_col + 1'b1;
                    end else begin
                        cur_row <= cur_row + 1'b1;
                    end
                    if (last_pix) begin
                        drain_cnt <= '0;
                        state     <= (state == S_SCAN_MINMAX) ? S_DRAIN_MINMAX : S_DRAIN_COUNT;
                    end
                end
                S_DRAIN_MINMAX, S_DRAIN_COUNT: begin
                    drain_cnt <= drain_cnt + 3'd1;
                    if (drain_cnt == 3'(READ_LATENCY)) begin
                        cur_row <= rs;
                        cur_col <= cs;
                        state   <= (state == S_DRAIN_MINMAX) ? S_SCAN_COUNT : S_EYE_DONE;
                    end
                end
                S_EYE_DONE: begin
                    res_valid_q  <= 1'b1;
                    res_eye_q    <= eye_idx;
                    res_err_q    <= err_q;
                    res_pupil_q  <= pupil;
                    res_sclera_q <= sclera;
                    res_open_q   <= {1'b0, pupil} + {1'b0, sclera};
                    if (eye_idx == EYE_W'(NUM_EYES - 1)) begin
                        state <= S_DONE;
                    end else begin
                        eye_idx <= eye_idx + 1'b1;
                        state   <= S_LOAD_EYE;
                    end
                end
                default: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase

            if (pix_vld && !count_pass) begin
                if (pixel_in < min_q) min_q <= pixel_in;
                if (pixel_in > max_q) max_q <= pixel_in;
            end
            if (win_full) begin
                if (pupil_hit && (pupil != '1))   pupil  <= pupil + 1'b1;
                if (sclera_hit && (sclera != '1)) sclera <= sclera + 1'b1;
            end
        end
    end

`ifdef EYE_REGION_STATS_EN
    logic [PIXEL_SIZE-1:0] res_min_q, res_max_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            res_min_q <= '0;
            res_max_q <= '0;
        end else if (state == S_EYE_DONE) begin
            res_min_q <= min_q;
            res_max_q <= max_q;
        end
    end

    assign result_min_out = res_min_q;
    assign result_max_out = res_max_q;
`endif

    assign pixel_addr_out       = addr_q;
    assign pixel_addr_valid_out = addr_valid_q;
    assign busy_out             = busy_q;
    assign done_out             = done_q;
    assign result_valid_out     = res_valid_q;
    assign result_eye_out       = res_eye_q;
    assign result_pupil_out     = res_pupil_q;
    assign result_sclera_out    = res_sclera_q;
    assign result_openness_out  = res_open_q;
    assign result_error_out     = res_err_q;

endmodule

// File: tb/tb_eye_region_scanner.sv
// tb/tb_eye_region_scanner.sv - directed bench: 1-eye/L2, 2-eye/L1 and 2-eye/L4 scanners on a shared frame model
module tb_eye_region_scanner;

    localparam int W = 180;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int mode = 0;
    int rs[2], re[2], cs[2], ce[2];
    int n_checks = 0;
    int n_fail = 0;
    int bad_addr = 0;
    int n_res[3], n_done[3];
    logic [31:0] r_pup[3][2], r_scl[3][2], r_opn[3][2], r_err[3][2];
    logic start_a, start_b, start_c;

    logic [8:0]  a_rs, a_re;
    logic [7:0]  a_cs, a_ce;
    logic [17:0] b_rs, b_re;
    logic [15:0] b_cs, b_ce;
    assign a_rs = 9'(rs[0]);
    assign a_re = 9'(re[0]);
    assign a_cs = 8'(cs[0]);
    assign a_ce = 8'(ce[0]);
    assign b_rs = {9'(rs[1]), 9'(rs[0])};
    assign b_re = {9'(re[1]), 9'(re[0])};
    assign b_cs = {8'(cs[1]), 8'(cs[0])};
    assign b_ce = {8'(ce[1]), 8'(ce[0])};

    logic [15:0] a_addr, b_addr, c_addr;
    logic        a_av, b_av, c_av, a_busy, b_busy, c_busy, a_rv, b_rv, c_rv;
    logic        a_eye, b_eye, c_eye, a_err, b_err, c_err, a_done, b_done, c_done;
    logic [15:0] a_pup, b_pup, c_pup, a_scl, b_scl, c_scl;
    logic [16:0] a_opn, b_opn, c_opn;
    logic [7:0]  a_pix, b_pix, c_pix;
`ifdef EYE_REGION_STATS_EN
    logic [7:0]  a_mn, a_mx, b_mn, b_mx, c_mn, c_mx;
`endif

    // Frame model: 0 uniform 50, 1 uniform 200, 2 rows 0..19 dark (40) and the rest bright (240)
    function automatic logic [7:0] pix(input logic [15:0] addr);
        case (mode)
            0:       return 8'd50;
            1:       return 8'd200;
            default: return (int'(addr) / W < 20) ? 8'd40 : 8'd240;
        endcase
    endfunction

    logic [7:0] a_pipe[2];
    logic [7:0] b_pipe;
    logic [7:0] c_pipe[4];
    always @(posedge clk) begin
        a_pipe[0] <= pix(a_addr);
        a_pipe[1] <= a_pipe[0];
        b_pipe    <= pix(b_addr);
        c_pipe[0] <= pix(c_addr);
        for (int i = 1; i < 4; i++) c_pipe[i] <= c_pipe[i-1];
    end
    assign a_pix = a_pipe[1];
    assign b_pix = b_pipe;
    assign c_pix = c_pipe[3];

    always @(negedge clk)
        if ((a_av && a_addr > 16'd57599) || (b_av && b_addr > 16'd57599) || (c_av && c_addr > 16'd57599))
            bad_addr <= bad_addr + 1;

    eye_region_scanner #(.NUM_EYES(1), .READ_LATENCY(2)) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a),
        .row_start_in(a_rs), .row_end_in(a_re), .col_start_in(a_cs), .col_end_in(a_ce),
        .pixel_addr_out(a_addr), .pixel_addr_valid_out(a_av), .pixel_in(a_pix),
        .busy_out(a_busy), .result_valid_out(a_rv), .result_eye_out(a_eye),
        .result_pupil_out(a_pup), .result_sclera_out(a_scl), .result_openness_out(a_opn),
        .result_error_out(a_err), .done_out(a_done)
`ifdef EYE_REGION_STATS_EN
        , .result_min_out(a_mn), .result_max_out(a_mx)
`endif
    );

    eye_region_scanner #(.NUM_EYES(2), .READ_LATENCY(1)) u_dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b),
        .row_start_in(b_rs), .row_end_in(b_re), .col_start_in(b_cs), .col_end_in(b_ce),
        .pixel_addr_out(b_addr), .pixel_addr_valid_out(b_av), .pixel_in(b_pix),
        .busy_out(b_busy), .result_valid_out(b_rv), .result_eye_out(b_eye),
        .result_pupil_out(b_pup), .result_sclera_out(b_scl), .result_openness_out(b_opn),
        .result_error_out(b_err), .done_out(b_done)
`ifdef EYE_REGION_STATS_EN
        , .result_min_out(b_mn), .result_max_out(b_mx)
`endif
    );

    eye_region_scanner #(.NUM_EYES(2), .READ_LATENCY(4)) u_dut_c (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start_c),
        .row_start_in(b_rs), .row_end_in(b_re), .col_start_in(b_cs), .col_end_in(b_ce),
        .pixel_addr_out(c_addr), .pixel_addr_valid_out(c_av), .pixel_in(c_pix),
        .busy_out(c_busy), .result_valid_out(c_rv), .result_eye_out(c_eye),
        .result_pupil_out(c_pup), .result_sclera_out(c_scl), .result_openness_out(c_opn),
        .result_error_out(c_err), .done_out(c_done)
`ifdef EYE_REGION_STATS_EN
        , .result_min_out(c_mn), .result_max_out(c_mx)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic record(input int d, input logic e, input logic [15:0] p, input logic [15:0] s,
                          input logic [16:0] o, input logic er);
        r_pup[d][e] = 32'(p);
        r_scl[d][e] = 32'(s);
        r_opn[d][e] = 32'(o);
        r_err[d][e] = 32'(er);
        n_res[d]++;
    endtask

    task automatic step();
        @(negedge clk);
        if (a_rv) record(0, a_eye, a_pup, a_scl, a_opn, a_err);
        if (b_rv) record(1, b_eye, b_pup, b_scl, b_opn, b_err);
        if (c_rv) record(2, c_eye, c_pup, c_scl, c_opn, c_err);
        if (a_done) begin n_done[0]++; start_a = 1'b0; end
        if (b_done) begin n_done[1]++; start_b = 1'b0; end
        if (c_done) begin n_done[2]++; start_c = 1'b0; end
    endtask

    task automatic run_frame(input string name, input int m, input bit hold);
        mode = m;
        for (int d = 0; d < 3; d++) begin
            n_res[d] = 0;
            n_done[d] = 0;
            for (int e = 0; e < 2; e++) begin
                r_pup[d][e] = 32'hDEAD; r_scl[d][e] = 32'hDEAD;
                r_opn[d][e] = 32'hDEAD; r_err[d][e] = 32'hDEAD;
            end
        end
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        step();
        if (!hold) begin start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; end
        for (int i = 0; i < 4000; i++) begin
            if (n_done[0] > 0 && n_done[1] > 0 && n_done[2] > 0) break;
            step();
        end
        repeat (12) step();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_eq($sformatf("%s.dut%0d.done_count", name, d), 32'(n_done[d]), 32'd1);
            check_eq($sformatf("%s.dut%0d.result_count", name, d), 32'(n_res[d]), (d == 0) ? 32'd1 : 32'd2);
        end
    endtask

    task automatic check_eye(input string name, input int d, input int e,
                             input int p, input int s, input int er);
        check_eq($sformatf("%s.dut%0d.eye%0d.pupil", name, d, e), r_pup[d][e], 32'(p));
        check_eq($sformatf("%s.dut%0d.eye%0d.sclera", name, d, e), r_scl[d][e], 32'(s));
        check_eq($sformatf("%s.dut%0d.eye%0d.openness", name, d, e), r_opn[d][e], 32'(p + s));
        check_eq($sformatf("%s.dut%0d.eye%0d.error", name, d, e), r_err[d][e], 32'(er));
    endtask

    task automatic frame_checks(input string name, input int p0, input int s0, input int e0,
                                input int p1, input int s1, input int e1);
        for (int d = 0; d < 3; d++) check_eye(name, d, 0, p0, s0, e0);
        for (int d = 1; d < 3; d++) check_eye(name, d, 1, p1, s1, e1);
    endtask

    task automatic set_region(input int eye, input int r0, input int r1, input int c0, input int c1);
        rs[eye] = r0; re[eye] = r1; cs[eye] = c0; ce[eye] = c1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        set_region(0, 0, 0, 0, 0);
        set_region(1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("reset.busy", 32'(a_busy), 32'd0);
        check_eq("reset.done", 32'(b_done), 32'd0);
        check_eq("reset.result_valid", 32'(c_rv), 32'd0);
        check_eq("reset.addr_valid", 32'(a_av), 32'd0);
        check_eq("reset.pupil", 32'(b_pup), 32'd0);
        rst_n = 1'b1;
        step();

        // Uniform 50, 20x2 region: 14 full windows per column; eye1 has row_end < row_start
        set_region(0, 10, 29, 5, 6);
        set_region(1, 29, 10, 5, 6);
        run_frame("uniform50", 0, 1'b0);
        frame_checks("uniform50", 28, 0, 0, 0, 0, 1);
`ifdef EYE_REGION_STATS_EN
        check_eq("uniform50.min", 32'(a_mn), 32'd50);
        check_eq("uniform50.max", 32'(a_mx), 32'd160);
`endif

        run_frame("uniform200", 1, 1'b0);
        frame_checks("uniform200", 0, 28, 0, 0, 0, 1);
`ifdef EYE_REGION_STATS_EN
        check_eq("uniform200.min", 32'(a_mn), 32'd90);
        check_eq("uniform200.max", 32'(a_mx), 32'd200);
`endif

        // Dark/bright split at row 20: windows ending rows 16..19 dark, 26..29 bright; eye1 is exactly WINDOW rows
        set_region(0, 10, 29, 5, 5);
        set_region(1, 0, 6, 0, 0);
        run_frame("split", 2, 1'b0);
        frame_checks("split", 4, 4, 0, 1, 0, 0);

        // 5-row columns contribute nothing; eye1 sits on the last row and column of the frame
        set_region(0, 10, 14, 5, 7);
        set_region(1, 300, 319, 179, 179);
        run_frame("short_edge", 0, 1'b0);
        frame_checks("short_edge", 0, 0, 0, 14, 0, 0);

        // Reset asserted away from the clock edge while every scanner is in its counting pass
        set_region(0, 10, 29, 5, 6);
        set_region(1, 29, 10, 5, 6);
        mode = 0;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1;
        step();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        repeat (60) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_reset.busy_a", 32'(a_busy), 32'd0);
        check_eq("async_reset.busy_c", 32'(c_busy), 32'd0);
        check_eq("async_reset.addr_valid_a", 32'(a_av), 32'd0);
        check_eq("async_reset.addr_c", 32'(c_addr), 32'd0);
        check_eq("async_reset.pupil_b", 32'(b_pup), 32'd0);
        check_eq("async_reset.result_valid_b", 32'(b_rv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_frame("after_reset", 0, 1'b0);
        frame_checks("after_reset", 28, 0, 0, 0, 0, 1);

        // start held high through the whole scan
        set_region(0, 10, 29, 5, 5);
        set_region(1, 0, 6, 0, 0);
        run_frame("held_start", 2, 1'b1);
        frame_checks("held_start", 4, 4, 0, 1, 0, 0);
        check_eq("held_start.busy_after", 32'(a_busy | b_busy | c_busy), 32'd0);

        check_eq("addr_range", 32'(bad_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
